// File: rtl/led_event_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// led_event_pkg
// Shared definitions for the LED event sequencer:
//   - lane intensity level constants (LVL_OFF .. LVL_HIGH)
//   - judgment grade encodings (miss/good/great/perfect)
//   - NUM_LANES, the number of judgment lanes
//   - lvl_max(): larger of two intensity levels
// -----------------------------------------------------------------------------
package led_event_pkg;

    localparam int NUM_LANES = 3;

    typedef logic [1:0] level_t;

    localparam level_t LVL_OFF  = 2'b00;
    localparam level_t LVL_LOW  = 2'b01;
    localparam level_t LVL_MID  = 2'b10;
    localparam level_t LVL_HIGH = 2'b11;

    typedef enum logic [1:0] {
        GRADE_MISS    = 2'b00,
        GRADE_GOOD    = 2'b01,
        GRADE_GREAT   = 2'b10,
        GRADE_PERFECT = 2'b11
    } grade_e;

    // Grades map one-to-one onto levels, so the larger of the two wins.
    function automatic level_t lvl_max(input level_t a, input level_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/led_event_sequencer_if.sv
// -----------------------------------------------------------------------------
// led_event_sequencer_if
// Event/brightness bus between the game core (master) and the sequencer
// (slave). Clock and reset are kept outside the interface.
//   judge_valid[2:0]  per-lane event strobe
//   judge_grade[5:0]  per-lane grade, lane i at [2i+1:2i]
//   bright_we/bright_wdata/bright_up/bright_dn  brightness controls
//   interrupt[5:0]    lane levels to the PWM interpreter
//   LedRGBBright[7:0] brightness to the PWM interpreter
//   tick              decay tick (debug)
//   combo[7:0]        combo counter, only when LED_EVENT_COMBO_EN is defined
// -----------------------------------------------------------------------------
interface led_event_sequencer_if;

    logic [2:0] judge_valid;
    logic [5:0] judge_grade;
    logic       bright_we;
    logic [7:0] bright_wdata;
    logic       bright_up;
    logic       bright_dn;
    logic [5:0] interrupt;
    logic [7:0] LedRGBBright;
    logic       tick;
`ifdef LED_EVENT_COMBO_EN
    logic [7:0] combo;
`endif

    modport master (
        output judge_valid, judge_grade, bright_we, bright_wdata, bright_up, bright_dn,
`ifdef LED_EVENT_COMBO_EN
        input  combo,
`endif
        input  interrupt, LedRGBBright, tick
    );

    modport slave (
        input  judge_valid, judge_grade, bright_we, bright_wdata, bright_up, bright_dn,
`ifdef LED_EVENT_COMBO_EN
        output combo,
`endif
        output interrupt, LedRGBBright, tick
    );

endinterface

// File: rtl/led_event_sequencer_lane_decay.sv
// -----------------------------------------------------------------------------
// led_lane_decay
// One lane: holds a 2-bit intensity level and a hold timer. An event sets the
// level (miss clears it, otherwise the level only rises) and reloads the timer;
// each decay tick counts the timer down and drops one level when it expires.
// An event in the same cycle as a tick takes precedence over the tick.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   event_i       event strobe for this lane
//   grade_i       grade of the event
//   tick_i        decay tick
//   level_o       current level (registered)
//   level_d_o     next level, lets the top register its packed output
// -----------------------------------------------------------------------------
module led_lane_decay
    import led_event_pkg::*;
#(
    parameter int HOLD_TICKS = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   event_i,
    input  logic [1:0] grade_i,
    input  logic   tick_i,
    output level_t level_o,
    output level_t level_d_o
);

    localparam int            TW   = $clog2(HOLD_TICKS + 1);
    localparam logic [TW-1:0] HOLD = TW'(HOLD_TICKS);

    level_t        level_q, level_d;
    logic [TW-1:0] timer_q, timer_d;

    // Next-state: event beats tick; level OFF or an empty timer ignores ticks.
    always_comb begin
        level_d = level_q;
        timer_d = timer_q;
        if (event_i) begin
            if (grade_i == GRADE_MISS) begin
                level_d = LVL_OFF;
                timer_d = {TW{1'b0}};
            end else begin
                level_d = lvl_max(level_q, level_t'(grade_i));
                timer_d = HOLD;
            end
        end else if (tick_i && (level_q != LVL_OFF) && (timer_q != {TW{1'b0}})) begin
            if (timer_q == TW'(1)) begin
                level_d = level_q - 2'b01;
                timer_d = (level_q == LVL_LOW) ? {TW{1'b0}} : HOLD;
            end else begin
                timer_d = timer_q - TW'(1);
            end
        end else begin
            level_d = level_q;
            timer_d = timer_q;
        end
    end

    // Lane state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= LVL_OFF;
            timer_q <= {TW{1'b0}};
        end else begin
            level_q <= level_d;
            timer_q <= timer_d;
        end
    end

    assign level_o   = level_q;
    assign level_d_o = level_d;

endmodule

// File: rtl/led_event_sequencer.sv
// -----------------------------------------------------------------------------
// led_event_sequencer
// Turns per-lane judgment events into the 6-bit interrupt level code and the
// 8-bit LedRGBBright value consumed by the RGB LED PWM interpreter.
// Contains the decay prescaler, the brightness register, optional combo logic
// and output packing; each lane is a led_lane_decay instance.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    led_event_sequencer_if.slave (events, brightness, outputs)
// Build option: define LED_EVENT_COMBO_EN to add the combo counter, the
// combo output and the full-intensity override.
// -----------------------------------------------------------------------------
module led_event_sequencer
    import led_event_pkg::*;
#(
    parameter int TICK_DIV    = 250000,
    parameter int HOLD_TICKS  = 4,
    parameter int BRIGHT_RST  = 128,
    parameter int BRIGHT_STEP = 16
`ifdef LED_EVENT_COMBO_EN
    ,
    parameter int COMBO_THRESH = 8
`endif
) (
    input  logic clk,
    input  logic rst_n,
    led_event_sequencer_if.slave bus
);

    localparam int               CW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]    LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic          tick_q;
    logic [7:0]    bright_q, bright_d;
    logic [8:0]    bright_up_s;
    logic [5:0]    irq_q, irq_d;
    level_t        level_s   [NUM_LANES];
    level_t        level_d_s [NUM_LANES];
    logic          boost_s;

    // Prescaler; tick is raised in the cycle where the counter reads 0 again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= {CW{1'b0}};
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= (cnt_q == LAST) ? {CW{1'b0}} : cnt_q + CW'(1);
            tick_q <= (cnt_q == LAST);
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        led_lane_decay #(.HOLD_TICKS(HOLD_TICKS)) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .event_i   (bus.judge_valid[i]),
            .grade_i   (bus.judge_grade[2*i +: 2]),
            .tick_i    (tick_q),
            .level_o   (level_s[i]),
            .level_d_o (level_d_s[i])
        );
    end

    // Brightness next-state: write beats steps, steps saturate at 0 and 255.
    always_comb begin
        bright_up_s = {1'b0, bright_q} + 9'(BRIGHT_STEP);
        bright_d    = bright_q;
        if (bus.bright_we) begin
            bright_d = bus.bright_wdata;
        end else if (bus.bright_up && !bus.bright_dn) begin
            bright_d = (bright_up_s > 9'd255) ? 8'd255 : bright_up_s[7:0];
        end else if (bus.bright_dn && !bus.bright_up) begin
            bright_d = ({1'b0, bright_q} < 9'(BRIGHT_STEP)) ? 8'd0 : 8'(bright_q - 8'(BRIGHT_STEP));
        end else begin
            bright_d = bright_q;
        end
    end

`ifdef LED_EVENT_COMBO_EN
    logic [7:0] combo_q, combo_d;
    logic       any_miss_s, any_hit_s;

    // Combo next-state: a miss on any lane clears, otherwise any hit counts once.
    always_comb begin
        any_miss_s = 1'b0;
        any_hit_s  = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (bus.judge_valid[i] && (bus.judge_grade[2*i +: 2] == GRADE_MISS)) begin
                any_miss_s = 1'b1;
            end else if (bus.judge_valid[i]) begin
                any_hit_s = 1'b1;
            end else begin
                any_hit_s = any_hit_s;
            end
        end
        if (any_miss_s) begin
            combo_d = 8'd0;
        end else if (any_hit_s && (combo_q != 8'd255)) begin
            combo_d = combo_q + 8'd1;
        end else begin
            combo_d = combo_q;
        end
    end

    // Combo counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            combo_q <= 8'd0;
        end else begin
            combo_q <= combo_d;
        end
    end

    assign boost_s   = ({24'd0, combo_d} >= 32'(COMBO_THRESH));
    assign bus.combo = combo_q;
`else
    assign boost_s = 1'b0;
`endif

    // Output packing from next-state so interrupt stays a registered output
    // while still showing an event one cycle after it arrives.
    always_comb begin
        irq_d = 6'd0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (boost_s && (level_d_s[i] != LVL_OFF)) begin
                irq_d[2*i +: 2] = LVL_HIGH;
            end else begin
                irq_d[2*i +: 2] = level_d_s[i];
            end
        end
    end

    // Brightness and interrupt output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bright_q <= 8'(BRIGHT_RST);
            irq_q    <= 6'd0;
        end else begin
            bright_q <= bright_d;
            irq_q    <= irq_d;
        end
    end

    assign bus.interrupt    = irq_q;
    assign bus.LedRGBBright = bright_q;
    assign bus.tick         = tick_q;

endmodule
